// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller.
// Moore FSM sequencing fetch, decode, memory, execute and write-back steps,
// with a retired-instruction counter and a sticky illegal-opcode flag.
//
// Memory handshake: in FETCH, MEMRD and MEMWR the strobe (mem_read or
// mem_write) is held asserted every cycle until the memory reports
// mem_ready=1; the access completes on the rising edge where mem_ready=1 and
// the FSM advances on that same edge. mem_ready is ignored in every other
// state.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             retire;   // current instruction finishes on this edge
    logic             bad_op;   // DECODE saw an unrecognised opcode

    // Next-state selection; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        bad_op  = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = IMMEX;
                    default: begin
                        state_d = FETCH;
                        bad_op  = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC:   state_d = RWB;
            IMMEX:  state_d = IMMWB;
            MEMWB, RWB, IMMWB, BRANCH, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // State, retired counter and sticky illegal flag; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (bad_op) illegal_q <= 1'b1;
        end
    end

    // Moore output decode, gated to all-zero while reset is held low.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        if (rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = 2'b11;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                RWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_source     = 2'b01;
                    pc_write_cond = 1'b1;
                end
                JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                IMMWB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (built with CNT_W=4 so the
// retired counter wraps after 16 instructions).
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       pc_write, pc_write_cond, pc_en;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
  logic       illegal;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .pc_en(pc_en), .state(state), .retired(retired), .illegal(illegal)
  );

  // Control word layout: [15] mem_read [14] mem_write [13] iord [12] ir_write
  // [11] reg_dst [10] mem_to_reg [9] reg_write [8] alu_src_a [7:6] alu_src_b
  // [5:4] alu_op [3] pc_write [2] pc_write_cond [1:0] pc_source
  logic [15:0] act_ctrl;
  assign act_ctrl = {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_write,
                     pc_write_cond, pc_source};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  logic exp_ill = 1'b0;
  logic last_pc_en = 1'b0;
  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output table taken straight from the per-state output list.
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
    logic [15:0] w;
    w = '0;
    case (st)
      0:  begin w[15] = 1'b1; w[7:6] = 2'b01; w[12] = rdy; w[3] = rdy; end
      1:  w[7:6] = 2'b11;
      2:  begin w[8] = 1'b1; w[7:6] = 2'b10; end
      3:  begin w[15] = 1'b1; w[13] = 1'b1; end
      4:  begin w[10] = 1'b1; w[9] = 1'b1; end
      5:  begin w[14] = 1'b1; w[13] = 1'b1; end
      6:  begin w[8] = 1'b1; w[5:4] = 2'b10; end
      7:  begin w[11] = 1'b1; w[9] = 1'b1; end
      8:  begin w[8] = 1'b1; w[5:4] = 2'b01; w[1:0] = 2'b01; w[2] = 1'b1; end
      9:  begin w[1:0] = 2'b10; w[3] = 1'b1; end
      10: begin w[8] = 1'b1; w[7:6] = 2'b10; end
      11: w[9] = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: drive at the falling edge, check shortly after.
  task automatic do_cycle(input logic [5:0] op, input logic z, input logic rdy,
                          input logic [3:0] exp_st);
    logic [15:0] w;
    @(negedge clk);
    opcode = op;
    zero = z;
    mem_ready = rdy;
    #1;
    w = exp_ctrl(int'(exp_st), rdy);
    chk("state", 32'(state), 32'(exp_st));
    chk("ctrl", 32'(act_ctrl), 32'(w));
    chk("pc_en", 32'(pc_en), 32'(w[3] | (w[2] & z)));
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    last_pc_en = pc_en;
  endtask

  task automatic push(input logic [3:0] s, input logic r);
    exp_q.push_back(s);
    rdy_q.push_back(r);
  endtask

  // Reference model: expands one instruction into its expected state walk,
  // then plays it through the DUT. zmode 0/1 fixes zero, 2 randomises it.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int zmode);
    logic [3:0] s;
    logic r, z;
    logic [5:0] o;
    for (int i = 0; i < fstall; i++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom_range(0, 1)));
    case (op)
      6'h00: begin push(4'd6, 1'($urandom_range(0, 1))); push(4'd7, 1'($urandom_range(0, 1))); end
      6'h23: begin
        push(4'd2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mstall; i++) push(4'd3, 1'b0);
        push(4'd3, 1'b1);
        push(4'd4, 1'($urandom_range(0, 1)));
      end
      6'h2B: begin
        push(4'd2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mstall; i++) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      6'h04: push(4'd8, 1'($urandom_range(0, 1)));
      6'h02: push(4'd9, 1'($urandom_range(0, 1)));
      6'h08: begin push(4'd10, 1'($urandom_range(0, 1))); push(4'd11, 1'($urandom_range(0, 1))); end
      default: ;
    endcase
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      r = rdy_q.pop_front();
      o = (s == 4'd1 || s == 4'd2) ? op : 6'($urandom_range(0, 63));
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      do_cycle(o, z, r, s);
    end
    if (is_legal(op)) exp_ret = (exp_ret + 1) % CNT_MOD;
    else exp_ill = 1'b1;
  endtask

  // Two reset edges with outputs checked for silence, then one FETCH wait cycle.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b1;
    opcode = 6'($urandom_range(0, 63));
    #1;
    chk("rst_ctrl", 32'(act_ctrl), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_ctrl2", 32'(act_ctrl), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("post_rst_state", 32'(state), 32'h0);
    chk("post_rst_mem_read", 32'(mem_read), 32'h1);
    chk("post_rst_ctrl", 32'(act_ctrl), 32'(exp_ctrl(0, 1'b0)));
    exp_ret = 0;
    exp_ill = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [5:0] op;
    logic       z;
    int         cycles;
    int         inc;
    logic       ill_after;
    int         pcen_cnt;
  } vec_t;

  vec_t vecs[9];
  logic [5:0] op_pool[6];

  initial begin
    int n, pcc;
    bit done;
    logic [5:0] op;

    vecs[0] = '{6'h00, 1'b0, 4, 1, 1'b0, 1};
    vecs[1] = '{6'h00, 1'b1, 4, 1, 1'b0, 1};
    vecs[2] = '{6'h23, 1'b1, 5, 1, 1'b0, 1};
    vecs[3] = '{6'h2B, 1'b0, 4, 1, 1'b0, 1};
    vecs[4] = '{6'h04, 1'b1, 3, 1, 1'b0, 2};
    vecs[5] = '{6'h04, 1'b0, 3, 1, 1'b0, 1};
    vecs[6] = '{6'h02, 1'b0, 3, 1, 1'b0, 2};
    vecs[7] = '{6'h08, 1'b1, 4, 1, 1'b0, 1};
    vecs[8] = '{6'h3F, 1'b0, 2, 0, 1'b1, 1};
    op_pool[0] = 6'h00; op_pool[1] = 6'h23; op_pool[2] = 6'h2B;
    op_pool[3] = 6'h04; op_pool[4] = 6'h02; op_pool[5] = 6'h08;

    apply_reset();

    // Latency / retire / illegal per opcode with mem_ready tied high.
    foreach (vecs[k]) begin
      n = 0;
      pcc = 0;
      done = 1'b0;
      while (!done && n < 20) begin
        @(negedge clk);
        opcode = vecs[k].op;
        zero = vecs[k].z;
        mem_ready = 1'b1;
        #1;
        if (pc_en) pcc++;
        @(posedge clk);
        #1;
        n++;
        if (state == 4'd0) done = 1'b1;
      end
      exp_ret = (exp_ret + vecs[k].inc) % CNT_MOD;
      if (vecs[k].ill_after) exp_ill = 1'b1;
      chk("vec_cycles", 32'(n), 32'(vecs[k].cycles));
      chk("vec_pc_en_cycles", 32'(pcc), 32'(vecs[k].pcen_cnt));
      chk("vec_retired", 32'(retired), 32'(exp_ret));
      chk("vec_illegal", 32'(illegal), 32'(vecs[k].ill_after));
    end

    apply_reset();

    // R-type walk 0,1,6,7,0 then retired=1.
    run_instr(6'h00, 0, 0, 2);
    // lw with three MEMRD wait cycles.
    run_instr(6'h23, 0, 3, 2);
    // beq taken then not taken.
    run_instr(6'h04, 1, 0, 1);
    chk("beq_taken_pc_en", 32'(last_pc_en), 32'h1);
    run_instr(6'h04, 0, 0, 0);
    chk("beq_not_taken_pc_en", 32'(last_pc_en), 32'h0);
    do_cycle(6'h00, 1'b0, 1'b0, 4'd0);
    chk("retired_after_seq", 32'(retired), 32'd4);

    // Illegal opcode, then reset in the middle of a MEMWR wait.
    run_instr(6'h3F, 1, 0, 2);
    do_cycle(6'h2B, 1'b0, 1'b1, 4'd0);
    do_cycle(6'h2B, 1'b0, 1'b0, 4'd1);
    do_cycle(6'h2B, 1'b0, 1'b0, 4'd2);
    do_cycle(6'h2B, 1'b0, 1'b0, 4'd5);
    do_cycle(6'h2B, 1'b0, 1'b0, 4'd5);
    apply_reset();

    // 16 jumps wrap the 4-bit retired counter back to 0.
    for (int i = 0; i < 16; i++) run_instr(6'h02, 0, 0, 2);
    do_cycle(6'h00, 1'b0, 1'b0, 4'd0);
    chk("wrap_retired", 32'(retired), 32'h0);

    // Randomised instruction stream with random stalls and noise inputs.
    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 6));
      op = (n == 6) ? 6'($urandom_range(0, 63)) : op_pool[n];
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2);
    end
    do_cycle(6'h00, 1'b0, 1'b0, 4'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
